sram_1rw_arbiter: RTL and testbench
===================================

Name: sram_1rw_arbiter

Overview:
Shares one single-port 256x256 SRAM macro between NUM_REQ requesters using valid/ready handshakes and round-robin arbitration. After reset, an init sequencer optionally zero-fills every entry before any requester is served. Read data is captured into a one-entry response register with backpressure. The block sits directly in front of the SRAM macro and drives its valid/write/addr/wdata pins.

Parameters:
NUM_REQ, 2, number of requesters (2..4)
ADDR_BITS, 8, SRAM address width (depth = 2**ADDR_BITS)
DATA_BITS, 256, SRAM word width
INIT_ZERO, 1, 1 = zero-fill the SRAM after reset; 0 = enter RUN directly

Ports:
clock  in  1  single clock; all state on rising edge
reset  in  1  asynchronous, active-low reset
req_valid  in  NUM_REQ  per-requester request valid
req_ready  out  NUM_REQ  per-requester grant (one-hot or zero)
req_write  in  NUM_REQ  1 = write, 0 = read
req_addr  in  NUM_REQ*ADDR_BITS  packed addresses; requester i at [i*ADDR_BITS +: ADDR_BITS]
req_wdata  in  NUM_REQ*DATA_BITS  packed write data
rsp_valid  out  NUM_REQ  read response valid for requester i (at most one bit set)
rsp_ready  in  NUM_REQ  response accept
rsp_data  out  DATA_BITS  shared read data, valid when any rsp_valid bit is set
init_done  out  1  high once zero-fill is complete
sram_valid  out  1  to macro valid
sram_write  out  1  to macro write
sram_addr  out  ADDR_BITS  to macro addr
sram_wdata  out  DATA_BITS  to macro wdata
sram_rdata  in  DATA_BITS  from macro rdata (mem[registered read addr])

Behaviour:
- Reset (reset=0, asynchronous): state=INIT if INIT_ZERO else RUN; init_cnt=0; rr_ptr=0; rd_inflight=0; hold_valid=0; all rsp_valid=0; init_done=0 (1 if INIT_ZERO=0); rsp_data=0. Outputs req_ready and sram_* are combinational and evaluate to 0 during reset.
- INIT: each cycle sram_valid=1, sram_write=1, sram_addr=init_cnt, sram_wdata=0; init_cnt increments. After address 2**ADDR_BITS-1 is written, go to RUN and set init_done=1 on the next edge. INIT therefore lasts exactly 256 cycles at default. req_ready=0 throughout.
- RUN: eligible(i) = req_valid[i] & (req_write[i] | rd_ok). rd_ok = !rd_inflight & (!hold_valid | rsp handshake this cycle).
- Grant goes to the first eligible requester at or after rr_ptr, searched cyclically. req_ready[grant]=1; the SRAM pins are driven from that requester with sram_valid=1. If no requester is eligible, sram_valid=0 and sram_addr/sram_wdata are 0.
- On a granted request, rr_ptr <= grant+1 mod NUM_REQ. rr_ptr does not move if there is no grant.
- Read pipeline: a read granted in cycle T sets rd_inflight for T+1, when sram_rdata is valid. At the end of T+1: hold_data <= sram_rdata, hold_owner <= requester, hold_valid <= 1, rd_inflight <= 0. rsp_valid[owner] is asserted from T+2, so read latency is 2 cycles. rsp_data = hold_data.
- A response is held stable until rsp_ready[owner]=1. The handshake clears hold_valid unless a capture happens on the same edge, in which case the new capture wins. rsp_ready on non-owner bits is ignored.
- Read throughput is at most one read per 2 cycles. Writes may be granted in any RUN cycle, including while rd_inflight=1 or hold_valid=1.
- A write to the in-flight read address in cycle T+1 does not affect captured data: capture takes the pre-write value (same-edge semantics).
- A requester must keep req_valid, req_write, req_addr and req_wdata stable until req_ready. The block does not check this.
- A read that is blocked by rd_ok does not block other requesters' writes: the read requester is skipped, not stalled on.
- Reset asserted mid-operation discards any in-flight read and the held response, and restarts INIT. No partial response is delivered.

Test Plan:
1. INIT_ZERO=1: release reset → 256 write cycles with addr 0..255 and wdata 0, init_done rises on cycle 257. Then read addr 0xFF from req0 → rsp_valid[0] 2 cycles after grant, rsp_data=0.
2. req0 writes addr 0x10 = 0xA5..A5, then reads 0x10 → rsp_data=0xA5..A5 exactly 2 cycles after the read grant; response held for 5 cycles while rsp_ready[0]=0.
3. req0 and req1 both issue continuous writes → grants alternate 0,1,0,1. A single requester active on its own gets a grant every cycle.
4. req0 issues continuous reads while req1 issues writes → req1 is granted during req0's rd_inflight cycle. req0 read grants are spaced at least 2 cycles apart, and none is granted while hold_valid=1 with no accept.
5. Read of 0x20 (old value X) granted at T, with req1 writing 0x20=Y at T+1 → rsp_data=X. A subsequent read returns Y.
6. Assert reset while hold_valid=1 and rd_inflight=1 → rsp_valid=0 and init_done=0 immediately (asynchronous); the INIT sequence reruns from addr 0.

Source files
------------

// File: rtl/sram_1rw_arbiter.sv
// sram_1rw_arbiter
//   Shares one single-port SRAM macro between NUM_REQ requesters. After reset
//   an optional init sequencer zero-fills the whole array, then requests are
//   granted round-robin. Reads come back two cycles after the grant through
//   a one-entry response register that holds until the owner accepts it.
//
// Ports
//   clock       : single clock, all state on the rising edge
//   reset       : asynchronous, active-low reset
//   req_valid   : per-requester request valid
//   req_ready   : per-requester grant (one-hot or zero)
//   req_write   : per-requester 1 = write, 0 = read
//   req_addr    : packed addresses, requester i at [i*ADDR_BITS +: ADDR_BITS]
//   req_wdata   : packed write data, requester i at [i*DATA_BITS +: DATA_BITS]
//   rsp_valid   : read response valid for its owner (at most one bit set)
//   rsp_ready   : per-requester response accept (only the owner's bit counts)
//   rsp_data    : shared read data
//   init_done   : high once the zero-fill has finished
//   sram_valid  : macro valid
//   sram_write  : macro write enable
//   sram_addr   : macro address
//   sram_wdata  : macro write data
//   sram_rdata  : macro read data, mem[registered read address]

module sram_1rw_arbiter #(
  parameter int NUM_REQ   = 2,
  parameter int ADDR_BITS = 8,
  parameter int DATA_BITS = 256,
  parameter int INIT_ZERO = 1
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [NUM_REQ-1:0]             req_valid,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic [NUM_REQ-1:0]             req_write,
  input  logic [NUM_REQ*ADDR_BITS-1:0]   req_addr,
  input  logic [NUM_REQ*DATA_BITS-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]             rsp_valid,
  input  logic [NUM_REQ-1:0]             rsp_ready,
  output logic [DATA_BITS-1:0]           rsp_data,
  output logic                           init_done,
  output logic                           sram_valid,
  output logic                           sram_write,
  output logic [ADDR_BITS-1:0]           sram_addr,
  output logic [DATA_BITS-1:0]           sram_wdata,
  input  logic [DATA_BITS-1:0]           sram_rdata
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [PTR_W:0]       NUM_REQ_W = (PTR_W+1)'(NUM_REQ);
  localparam logic [PTR_W-1:0]     LAST_REQ  = PTR_W'(NUM_REQ - 1);
  localparam logic [ADDR_BITS-1:0] LAST_ADDR = '1;

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } state_t;

  localparam state_t RESET_STATE = (INIT_ZERO != 0) ? ST_INIT : ST_RUN;
  localparam logic   RESET_DONE  = (INIT_ZERO != 0) ? 1'b0 : 1'b1;

  state_t                 state_q, state_d;
  logic [ADDR_BITS-1:0]   initCnt_q, initCnt_d;
  logic                   initDone_q, initDone_d;
  logic [PTR_W-1:0]       rrPtr_q, rrPtr_d;
  logic                   rdInflight_q, rdInflight_d;
  logic [PTR_W-1:0]       rdOwner_q, rdOwner_d;
  logic                   holdValid_q, holdValid_d;
  logic [PTR_W-1:0]       holdOwner_q, holdOwner_d;
  logic [DATA_BITS-1:0]   holdData_q, holdData_d;

  logic                   rspHs;
  logic                   rdOk;
  logic [NUM_REQ-1:0]     eligible;
  logic [PTR_W:0]         cand;
  logic                   gntFound;
  logic [PTR_W-1:0]       gntIdx;
  logic                   rdStart;
  logic [NUM_REQ-1:0]     reqReady;
  logic                   sramValid;
  logic                   sramWrite;
  logic [ADDR_BITS-1:0]   sramAddr;
  logic [DATA_BITS-1:0]   sramWdata;

  // A read may only start when the pipeline slot is free and the response
  // register will be empty at the capture edge (either already empty or being
  // accepted right now). Reads that cannot start are skipped, so writes from
  // other requesters still get through.
  always_comb begin
    state_d      = state_q;
    initCnt_d    = initCnt_q;
    initDone_d   = initDone_q;
    rrPtr_d      = rrPtr_q;
    rdOwner_d    = rdOwner_q;
    holdValid_d  = holdValid_q;
    holdOwner_d  = holdOwner_q;
    holdData_d   = holdData_q;
    cand         = '0;
    gntFound     = 1'b0;
    gntIdx       = '0;
    rdStart      = 1'b0;
    reqReady     = '0;
    sramValid    = 1'b0;
    sramWrite    = 1'b0;
    sramAddr     = '0;
    sramWdata    = '0;

    rspHs    = holdValid_q && rsp_ready[holdOwner_q];
    rdOk     = !rdInflight_q && (!holdValid_q || rspHs);
    eligible = req_valid & (req_write | {NUM_REQ{rdOk}});

    case (state_q)
      ST_INIT: begin
        sramValid = 1'b1;
        sramWrite = 1'b1;
        sramAddr  = initCnt_q;
        initCnt_d = initCnt_q + 1'b1;
        if (initCnt_q == LAST_ADDR) begin
          state_d    = ST_RUN;
          initDone_d = 1'b1;
        end
      end
      ST_RUN: begin
        // Cyclic search starting at the round-robin pointer.
        for (int k = 0; k < NUM_REQ; k++) begin
          cand = {1'b0, rrPtr_q} + (PTR_W+1)'(k);
          if (cand >= NUM_REQ_W) begin
            cand = cand - NUM_REQ_W;
          end
          if (!gntFound && eligible[cand[PTR_W-1:0]]) begin
            gntFound = 1'b1;
            gntIdx   = cand[PTR_W-1:0];
          end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
          if (gntFound && (gntIdx == PTR_W'(i))) begin
            reqReady[i] = 1'b1;
            sramValid   = 1'b1;
            sramWrite   = req_write[i];
            sramAddr    = req_addr[i*ADDR_BITS +: ADDR_BITS];
            sramWdata   = req_wdata[i*DATA_BITS +: DATA_BITS];
            rdStart     = !req_write[i];
          end
        end
        if (gntFound) begin
          rrPtr_d = (gntIdx == LAST_REQ) ? '0 : gntIdx + 1'b1;
        end
      end
      default: begin
        state_d = ST_INIT;
      end
    endcase

    if (rdStart) begin
      rdOwner_d = gntIdx;
    end

    // A capture on the same edge as an accept wins over the clear.
    if (rdInflight_q) begin
      holdValid_d = 1'b1;
      holdOwner_d = rdOwner_q;
      holdData_d  = sram_rdata;
    end else if (rspHs) begin
      holdValid_d = 1'b0;
    end

    // Combinational outputs must read zero while reset is held.
    if (!reset) begin
      reqReady  = '0;
      sramValid = 1'b0;
      sramWrite = 1'b0;
      sramAddr  = '0;
      sramWdata = '0;
    end
  end

  assign rdInflight_d = rdStart;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= RESET_STATE;
      initCnt_q    <= '0;
      initDone_q   <= RESET_DONE;
      rrPtr_q      <= '0;
      rdInflight_q <= 1'b0;
      rdOwner_q    <= '0;
      holdValid_q  <= 1'b0;
      holdOwner_q  <= '0;
      holdData_q   <= '0;
    end else begin
      state_q      <= state_d;
      initCnt_q    <= initCnt_d;
      initDone_q   <= initDone_d;
      rrPtr_q      <= rrPtr_d;
      rdInflight_q <= rdInflight_d;
      rdOwner_q    <= rdOwner_d;
      holdValid_q  <= holdValid_d;
      holdOwner_q  <= holdOwner_d;
      holdData_q   <= holdData_d;
    end
  end

  always_comb begin
    rsp_valid = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      rsp_valid[i] = holdValid_q && (holdOwner_q == PTR_W'(i));
    end
  end

  assign req_ready  = reqReady;
  assign sram_valid = sramValid;
  assign sram_write = sramWrite;
  assign sram_addr  = sramAddr;
  assign sram_wdata = sramWdata;
  assign rsp_data   = holdData_q;
  assign init_done  = initDone_q;

endmodule

// File: tb/tb_sram_1rw_arbiter.sv
// Testbench for sram_1rw_arbiter: behavioural SRAM macro, a cycle-level
// reference model that checks every DUT output on every negedge, a table of
// directed transactions, hand-written corner-case sequences and a random run.

module tb_sram_1rw_arbiter;

  localparam int N  = 2;
  localparam int AW = 8;
  localparam int DW = 256;

  logic            clock;
  logic            reset;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N-1:0]    req_write;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [N-1:0]    rsp_valid;
  logic [N-1:0]    rsp_ready;
  logic [DW-1:0]   rsp_data;
  logic            init_done;
  logic            sram_valid;
  logic            sram_write;
  logic [AW-1:0]   sram_addr;
  logic [DW-1:0]   sram_wdata;
  logic [DW-1:0]   sram_rdata;

  int checks = 0;
  int errors = 0;

  sram_1rw_arbiter #(
    .NUM_REQ(N), .ADDR_BITS(AW), .DATA_BITS(DW), .INIT_ZERO(1)
  ) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .init_done(init_done),
    .sram_valid(sram_valid), .sram_write(sram_write), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
  );

  // 100 MHz clock.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Hard time limit so the bench can never hang.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Behavioural macro: synchronous write, registered read address.
  logic [DW-1:0] macroMem [256];
  logic [AW-1:0] macroRaddr;
  always @(posedge clock) begin
    if (sram_valid) begin
      if (sram_write) macroMem[sram_addr] <= sram_wdata;
      else            macroRaddr <= sram_addr;
    end
  end
  assign sram_rdata = macroMem[macroRaddr];

  task automatic checkOutput(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference model state: transaction-level view of the arbiter.
  logic [DW-1:0] refMem [256];
  bit            mInitPhase;
  int            mCnt;
  int            mPtr;
  bit            mInfl;
  int            mInflAddr;
  int            mInflOwner;
  bit            mHoldV;
  int            mHoldOwner;
  logic [DW-1:0] mHoldData;
  logic [N-1:0]  mGntMask;

  bit            cCommit;
  bit            cHs;
  int            cGnt;
  bit            cWrite;
  int            cAddr;
  logic [DW-1:0] cData;

  // The model predicts every output from its own rules each negedge, then
  // advances one step at the following posedge using the same inputs.
  initial begin
    logic [N-1:0]  expReady;
    logic [N-1:0]  expRsp;
    logic          expSV;
    logic          expSW;
    logic [AW-1:0] expSA;
    logic [DW-1:0] expSD;
    bit            rdOk;
    int            idx;
    mInitPhase = 1'b1;
    mGntMask   = '0;
    forever begin
      @(negedge clock);
      cCommit  = 1'b0;
      cGnt     = -1;
      cHs      = 1'b0;
      mGntMask = '0;
      if (!reset) begin
        mInitPhase = 1'b1;
        mCnt       = 0;
        mPtr       = 0;
        mInfl      = 1'b0;
        mHoldV     = 1'b0;
        mHoldOwner = 0;
        mHoldData  = '0;
        checkOutput("rstReady", req_ready, '0);
        checkOutput("rstSramValid", sram_valid, '0);
        checkOutput("rstSramAddr", sram_addr, '0);
        checkOutput("rstRspValid", rsp_valid, '0);
        checkOutput("rstRspData", rsp_data, '0);
        checkOutput("rstInitDone", init_done, '0);
      end else begin
        cCommit  = 1'b1;
        expReady = '0;
        expSV    = 1'b0;
        expSW    = 1'b0;
        expSA    = '0;
        expSD    = '0;
        if (mInitPhase) begin
          expSV = 1'b1;
          expSW = 1'b1;
          expSA = AW'(mCnt);
        end else begin
          cHs  = mHoldV && rsp_ready[mHoldOwner];
          rdOk = !mInfl && (!mHoldV || cHs);
          for (int k = 0; k < N; k++) begin
            idx = (mPtr + k) % N;
            if (cGnt < 0 && req_valid[idx] && (req_write[idx] || rdOk)) cGnt = idx;
          end
          if (cGnt >= 0) begin
            expReady[cGnt] = 1'b1;
            expSV  = 1'b1;
            expSW  = req_write[cGnt];
            expSA  = req_addr[cGnt*AW +: AW];
            expSD  = req_wdata[cGnt*DW +: DW];
            cWrite = req_write[cGnt];
            cAddr  = int'(req_addr[cGnt*AW +: AW]);
            cData  = req_wdata[cGnt*DW +: DW];
          end
        end
        expRsp = '0;
        if (mHoldV) expRsp[mHoldOwner] = 1'b1;
        mGntMask = expReady;
        checkOutput("mReady", req_ready, expReady);
        checkOutput("mSramValid", sram_valid, expSV);
        checkOutput("mSramWrite", sram_write, expSW);
        checkOutput("mSramAddr", sram_addr, expSA);
        checkOutput("mSramWdata", sram_wdata, expSD);
        checkOutput("mRspValid", rsp_valid, expRsp);
        checkOutput("mRspData", rsp_data, mHoldData);
        checkOutput("mInitDone", init_done, !mInitPhase);
      end
      @(posedge clock);
      if (cCommit) begin
        if (mInitPhase) begin
          refMem[mCnt] = '0;
          if (mCnt == 255) mInitPhase = 1'b0;
          else             mCnt++;
        end else begin
          if (mInfl) begin
            mHoldData  = refMem[mInflAddr];
            mHoldV     = 1'b1;
            mHoldOwner = mInflOwner;
          end else if (cHs) begin
            mHoldV = 1'b0;
          end
          mInfl = (cGnt >= 0) && !cWrite;
          if (cGnt >= 0) begin
            mInflAddr  = cAddr;
            mInflOwner = cGnt;
            if (cWrite) refMem[cAddr] = cData;
            mPtr = (cGnt + 1) % N;
          end
        end
      end
    end
  end

  function automatic logic [DW-1:0] randWord();
    logic [DW-1:0] w;
    for (int j = 0; j < DW/32; j++) w[j*32 +: 32] = $urandom;
    return w;
  endfunction

  task automatic applyStimulus(input int who, input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid[who]          = 1'b1;
    req_write[who]          = wr;
    req_addr[who*AW +: AW]  = a;
    req_wdata[who*DW +: DW] = d;
  endtask

  task automatic waitGrant(input int who);
    int n;
    n = 0;
    @(negedge clock);
    while (!req_ready[who] && n < 20) begin
      @(negedge clock);
      n++;
    end
    checkOutput("grantWait", (n < 20), 1);
  endtask

  // Counts cycles from reset release until init_done; the first cycle must
  // write address 0 and init_done must be seen in cycle 257.
  task automatic waitInit();
    int n;
    n = 0;
    do begin
      @(negedge clock);
      n++;
      if (n == 1) checkOutput("initFirstAddr", sram_addr, '0);
    end while (!init_done && n < 400);
    checkOutput("initCycles", n, 257);
  endtask

  // One transaction: wait for the grant, and for reads check the 2-cycle
  // latency, the data, and that the response holds while not accepted.
  task automatic doTxn(input int who, input bit wr, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic [DW-1:0] exp, input int holdCycles);
    int lat;
    @(posedge clock); #1;
    rsp_ready = '0;
    applyStimulus(who, wr, a, d);
    waitGrant(who);
    @(posedge clock); #1;
    req_valid[who] = 1'b0;
    if (!wr) begin
      lat = 1;
      @(negedge clock);
      while (!rsp_valid[who] && lat < 10) begin
        @(negedge clock);
        lat++;
      end
      checkOutput("rdLatency", lat, 2);
      checkOutput("rdData", rsp_data, exp);
      for (int h = 0; h < holdCycles; h++) begin
        @(negedge clock);
        checkOutput("rspHeldValid", rsp_valid[who], 1);
        checkOutput("rspHeldData", rsp_data, exp);
      end
      @(posedge clock); #1;
      rsp_ready[who] = 1'b1;
      @(posedge clock); #1;
      rsp_ready[who] = 1'b0;
    end
  endtask

  // One cycle of random traffic; a request is replaced only after the model
  // saw it granted, so requests stay stable until ready.
  task automatic randomCycle();
    @(posedge clock); #1;
    for (int i = 0; i < N; i++) begin
      if (!req_valid[i] || mGntMask[i]) begin
        applyStimulus(i, $urandom_range(0, 1), AW'($urandom_range(0, 7)), randWord());
        req_valid[i] = ($urandom_range(0, 2) != 0);
      end
    end
    rsp_ready = N'($urandom);
  endtask

  typedef struct {
    int            who;
    bit            wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] expData;
    int            hold;
  } txn_t;

  // Main test sequence.
  initial begin
    txn_t          tbl [8];
    logic [N-1:0]  g [12];
    int            n0;
    logic [DW-1:0] xVal;
    logic [DW-1:0] yVal;

    xVal = {32{8'h11}};
    yVal = {32{8'h22}};
    tbl[0] = '{0, 1'b0, 8'hFF, '0,             '0,             0};
    tbl[1] = '{0, 1'b1, 8'h10, {32{8'hA5}},    '0,             0};
    tbl[2] = '{0, 1'b0, 8'h10, '0,             {32{8'hA5}},    5};
    tbl[3] = '{1, 1'b1, 8'h33, {32{8'h3C}},    '0,             0};
    tbl[4] = '{1, 1'b0, 8'h33, '0,             {32{8'h3C}},    0};
    tbl[5] = '{0, 1'b0, 8'h33, '0,             {32{8'h3C}},    1};
    tbl[6] = '{1, 1'b1, 8'h00, {DW{1'b1}},     '0,             0};
    tbl[7] = '{0, 1'b0, 8'h00, '0,             {DW{1'b1}},     0};

    reset     = 1'b0;
    req_valid = '0;
    req_write = '0;
    req_addr  = '0;
    req_wdata = '0;
    rsp_ready = '0;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b1;
    $display("[TB] reset released, waiting for zero-fill");
    waitInit();

    $display("[TB] directed transaction table");
    for (int t = 0; t < 8; t++) begin
      doTxn(tbl[t].who, tbl[t].wr, tbl[t].addr, tbl[t].wdata, tbl[t].expData, tbl[t].hold);
    end

    $display("[TB] competing writes");
    @(posedge clock); #1;
    applyStimulus(0, 1'b1, 8'h40, {32{8'h40}});
    applyStimulus(1, 1'b1, 8'h41, {32{8'h41}});
    for (int k = 0; k < 6; k++) begin
      @(negedge clock);
      g[k] = req_ready;
    end
    for (int k = 1; k < 6; k++) checkOutput("wrAlternate", g[k] ^ g[k-1], 2'b11);
    @(posedge clock); #1;
    req_valid[1] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      checkOutput("soloEveryCycle", req_ready, 2'b01);
    end
    @(posedge clock); #1;
    req_valid = '0;

    $display("[TB] reads against writes");
    @(posedge clock); #1;
    rsp_ready = 2'b01;
    applyStimulus(0, 1'b0, 8'h10, '0);
    applyStimulus(1, 1'b1, 8'h50, {32{8'h50}});
    for (int k = 0; k < 12; k++) begin
      @(negedge clock);
      g[k] = req_ready;
    end
    @(posedge clock); #1;
    req_valid = '0;
    repeat (4) @(posedge clock);
    #1;
    rsp_ready = '0;
    n0 = 0;
    for (int k = 0; k < 12; k++) begin
      if (g[k][0]) begin
        n0++;
        if (k < 11) checkOutput("wrDuringInflight", g[k+1], 2'b10);
      end
    end
    checkOutput("rdGrantCount", n0, 6);

    $display("[TB] write behind in-flight read");
    doTxn(1, 1'b1, 8'h20, xVal, '0, 0);
    @(posedge clock); #1;
    applyStimulus(0, 1'b0, 8'h20, '0);
    waitGrant(0);
    @(posedge clock); #1;
    req_valid[0] = 1'b0;
    applyStimulus(1, 1'b1, 8'h20, yVal);
    @(negedge clock);
    checkOutput("t5WriteGranted", req_ready, 2'b10);
    @(posedge clock); #1;
    req_valid[1] = 1'b0;
    @(negedge clock);
    checkOutput("t5RspValid", rsp_valid, 2'b01);
    checkOutput("t5OldData", rsp_data, xVal);
    @(posedge clock); #1;
    rsp_ready = 2'b01;
    @(posedge clock); #1;
    rsp_ready = '0;
    doTxn(0, 1'b0, 8'h20, '0, yVal, 0);

    $display("[TB] random traffic");
    for (int c = 0; c < 600; c++) randomCycle();
    @(posedge clock); #1;
    req_valid = '0;
    rsp_ready = '1;
    repeat (4) @(posedge clock);
    #1;
    rsp_ready = '0;

    $display("[TB] reset during in-flight read");
    applyStimulus(0, 1'b0, 8'h10, '0);
    waitGrant(0);
    @(posedge clock); #1;
    req_valid = '0;
    reset = 1'b0;
    #1;
    checkOutput("rstInflRspValid", rsp_valid, '0);
    checkOutput("rstInflInitDone", init_done, 1'b0);
    checkOutput("rstInflSramValid", sram_valid, 1'b0);
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
    waitInit();

    $display("[TB] reset during held response");
    @(posedge clock); #1;
    applyStimulus(1, 1'b1, 8'h10, {32{8'h77}});
    waitGrant(1);
    @(posedge clock); #1;
    req_valid = '0;
    applyStimulus(0, 1'b0, 8'h10, '0);
    waitGrant(0);
    @(posedge clock); #1;
    req_valid = '0;
    @(negedge clock);
    @(negedge clock);
    checkOutput("preRstHeld", rsp_valid, 2'b01);
    @(posedge clock); #1;
    reset = 1'b0;
    #1;
    checkOutput("rstHoldRspValid", rsp_valid, '0);
    checkOutput("rstHoldRspData", rsp_data, '0);
    checkOutput("rstHoldInitDone", init_done, 1'b0);
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
    waitInit();
    doTxn(0, 1'b0, 8'h10, '0, '0, 0);

    repeat (2) @(posedge clock);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
